// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the rising-to-rising period of a slow asynchronous
// square wave (clk_in) in clk cycles, flags lock when LOCK_CNT consecutive
// periods fall within TOL of EXP_PERIOD, and flags loss after TIMEOUT cycles
// without a rising edge.
// Optional build macro CLK_PERIOD_METER_DUTY_EN adds high-phase measurement on
// high_time; without it high_time is held at 0.
module clk_period_meter #(
  parameter int CNT_W      = 26,
  parameter int EXP_PERIOD = 20000000,
  parameter int TOL        = 1000,
  parameter int TIMEOUT    = 40000000,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] high_time
);

  localparam logic [CNT_W-1:0] EXP_C      = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [3:0]       LOCK_C     = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOST = 2'd2
  } state_t;

  // Synchronizer and edge-detect flops
  logic sync1_q, sync2_q, prev_q;
  logic rise_s;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  // Match evaluation helpers
  logic [CNT_W-1:0] cnt_p1_s;
  logic [CNT_W-1:0] diff_s;
  logic             match_s;

  // High-phase value offered to high_time on each period update
  logic [CNT_W-1:0] high_src_s;

  // Two-flop synchronizer followed by the previous-value flop for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_s = sync2_q & ~prev_q;

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic             fall_s;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] hcnt_inc_s;

  assign fall_s     = ~sync2_q & prev_q;
  assign hcnt_inc_s = (hcnt_q == {CNT_W{1'b1}}) ? hcnt_q : (hcnt_q + ONE_C);

  // High-phase counter restarts on rise; shadow captures its value on fall
  always_comb begin
    hcnt_d   = hcnt_inc_s;
    shadow_d = shadow_q;
    if (rise_s) begin
      hcnt_d   = {CNT_W{1'b0}};
      shadow_d = {CNT_W{1'b0}};
    end else if (fall_s) begin
      shadow_d = hcnt_inc_s;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // High-phase counter and shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q   <= {CNT_W{1'b0}};
      shadow_q <= {CNT_W{1'b0}};
    end else begin
      hcnt_q   <= hcnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign high_src_s = shadow_q;
`else
  assign high_src_s = {CNT_W{1'b0}};
`endif

  // Period and distance from the expected value (larger minus smaller)
  assign cnt_p1_s = cnt_q + ONE_C;
  assign diff_s   = (cnt_p1_s >= EXP_C) ? (cnt_p1_s - EXP_C) : (EXP_C - cnt_p1_s);
  assign match_s  = (diff_s <= TOL_C);

  // Next-state and output logic of the measurement FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcnt_d      = mcnt_q;
    period_d    = period_q;
    vld_d       = 1'b0;
    locked_d    = locked_q;
    lost_d      = lost_q;
    high_time_d = high_time_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (rise_s) begin
          state_d = ST_MEAS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (rise_s) begin
          // A rise on the timeout cycle still completes a normal period
          cnt_d       = {CNT_W{1'b0}};
          period_d    = cnt_p1_s;
          vld_d       = 1'b1;
          high_time_d = high_src_s;
          if (match_s) begin
            if (mcnt_q < LOCK_C) begin
              mcnt_d = mcnt_q + 4'd1;
            end else begin
              mcnt_d = mcnt_q;
            end
            if (mcnt_q >= (LOCK_C - 4'd1)) begin
              locked_d = 1'b1;
            end else begin
              locked_d = locked_q;
            end
          end else begin
            mcnt_d   = 4'd0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == TMO_LAST_C) begin
          state_d  = ST_LOST;
          lost_d   = 1'b1;
          locked_d = 1'b0;
          mcnt_d   = 4'd0;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_LOST: begin
        // Partial period after loss is discarded: no period update here
        cnt_d = {CNT_W{1'b0}};
        if (rise_s) begin
          state_d = ST_MEAS;
          lost_d  = 1'b0;
        end else begin
          state_d = ST_LOST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mcnt_q      <= 4'd0;
      period_q    <= {CNT_W{1'b0}};
      vld_q       <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      high_time_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcnt_q      <= mcnt_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
      high_time_q <= high_time_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign lost       = lost_q;
  assign high_time  = high_time_q;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side companion to the team's counter-based clock dividers.
- Measures the period of a slow, asynchronous square wave on clk_in in units of clk cycles.
- Flags lock when consecutive periods match an expected value within tolerance, and flags loss when edges stop.
- Sits after a divider output or an external slow reference; used for self-check and for bring-up of the divided clock.

Parameters:
- CNT_W, 26, width of period counter and period output.
- EXP_PERIOD, 20000000, expected full period in clk cycles (a divider toggling every N cycles gives 2N).
- TOL, 1000, allowed absolute deviation from EXP_PERIOD, in clk cycles.
- TIMEOUT, 40000000, cycles without a rising edge before declaring loss; must be < 2^CNT_W.
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert locked (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_in  in  1  asynchronous slow clock under measurement
- period  out  CNT_W  last measured rising-to-rising period, in clk cycles
- period_vld  out  1  one-cycle pulse when period updates
- locked  out  1  level, lock achieved
- lost  out  1  level, no rising edge within TIMEOUT
- high_time  out  CNT_W  last measured high phase (see Optional Feature)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- clk_in passes through a 2-flop synchronizer, then a registered previous-value flop.
- rise = sync & ~prev. Edge-to-detect latency is 3 clk cycles, constant for all edges.
- Reset values:
  - period=0, period_vld=0, locked=0, lost=0, high_time=0.
  - Counter, match counter and sync flops cleared; FSM = IDLE.
- FSM states:
  - IDLE: waiting for the first rising edge; counter held at 0.
  - MEAS: counter runs.
  - LOST: loss declared.
- IDLE -> MEAS on rise; cnt<=0. No period_vld for this first edge.
- MEAS, rise cycle:
  - period<=cnt+1 (exact distance between consecutive rise cycles); period_vld=1 on the next cycle; cnt<=0.
  - Match evaluation: match = |(cnt+1) - EXP_PERIOD| <= TOL, using unsigned compare of the larger minus the smaller.
  - On match: match counter increments, saturating at LOCK_CNT. locked=1 the cycle period_vld pulses for the LOCK_CNT-th consecutive match.
  - On mismatch: match counter<=0 and locked<=0 in the same cycle period updates.
- MEAS, no rise: cnt increments.
  - When cnt == TIMEOUT-1: go to LOST, lost<=1, locked<=0, match counter<=0, cnt<=0.
  - Never wraps.
- LOST:
  - lost stays 1 and the counter is idle.
  - On rise: go to MEAS, lost<=0, cnt<=0, no period_vld (partial period discarded).
- Rise on the same cycle cnt reaches TIMEOUT-1: rise wins; the period is recorded normally.
- rst mid-measurement: everything returns to reset values next cycle; the next rise is treated as the first edge.
- period, high_time and locked hold between updates.
- period_vld is never high on two consecutive cycles.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined:
  - A falling-edge detect (fall = ~sync & prev) runs alongside rise.
  - A second counter is cleared on rise and captured on fall into a shadow register.
  - high_time is updated from the shadow register on the same cycle as period, i.e. the high phase of the period just completed.
  - A missing fall within a period gives high_time=0.
- Undefined: no falling-edge logic; high_time is tied to 0.

Test Plan:
- Bench parameters: CNT_W=8, EXP_PERIOD=20, TOL=1, TIMEOUT=64, LOCK_CNT=4.
- Steady clk_in, period 20 (10 high / 10 low), after reset:
  - First rise: no period_vld.
  - Each following period: period_vld with period=20.
  - locked=1 on the 4th pulse; lost stays 0.
- Locked, then one period of 23: period=23, locked drops on that pulse. Periods of 19 and 21 then re-lock after 4 pulses.
- Locked, then clk_in held low: lost=1 and locked=0 exactly 64 cycles after the last rise-detect cycle. A new rise clears lost with no period_vld; the next period gives period_vld.
- Rise landing on the cnt==63 cycle: period=64, period_vld=1, lost stays 0.
- rst pulsed mid-period while locked: all outputs 0 next cycle; the first subsequent rise produces no pulse.
- DUTY_EN build, 6 high / 14 low: high_time=6 with period=20. Non-DUTY build: high_time=0 always.
